// File: rtl/control_unit_if.sv
// control_unit_if: instruction fields in, registered datapath controls out.
interface control_unit_if;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Muxrs1;
  logic [1:0] Op1;
  logic [1:0] ALU;
  logic       WriteEnable;
  logic       MemWrite;
  logic [2:0] Op2;
  modport master (output Opcode, Funct3, input Muxrs1, Op1, ALU, WriteEnable, MemWrite, Op2);
  modport slave (input Opcode, Funct3, output Muxrs1, Op1, ALU, WriteEnable, MemWrite, Op2);
endinterface

// File: rtl/control_unit.sv
// control_unit: registered RV32I-subset main decoder; illegal encodings register the all-zero reset vector.
module control_unit (
  input logic clock,
  input logic resetn,
  control_unit_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  logic       alu_ok;
  logic [1:0] alu_op;
  logic [9:0] nxt;
  // Supported ALU funct3 codes 000/101/110/111 map to ADD/SRL/OR/AND via {f3[2]&f3[1], f3[2]&f3[0]}.
  always_comb begin
    alu_ok = (bus.Funct3 == 3'b000) || (bus.Funct3 == 3'b101) || (bus.Funct3[2:1] == 2'b11);
    alu_op = {bus.Funct3[2] & bus.Funct3[1], bus.Funct3[2] & bus.Funct3[0]};
    nxt = '0;
    nxt = (bus.Opcode == OP_R && alu_ok) ? {1'b0, 2'b00, alu_op, 1'b1, 1'b0, 3'b000} :
          (bus.Opcode == OP_I && alu_ok) ? {1'b0, 2'b00, alu_op, 1'b1, 1'b0, (bus.Funct3 == 3'b101) ? 3'b100 : 3'b001} :
          (bus.Opcode == OP_LUI) ? {1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 3'b011} :
          (bus.Opcode == OP_LOAD && bus.Funct3 == 3'b010) ? {1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 3'b001} :
          (bus.Opcode == OP_STORE && bus.Funct3 == 3'b010) ? {1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 3'b010} :
          10'd0;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) {bus.Muxrs1, bus.Op1, bus.ALU, bus.WriteEnable, bus.MemWrite, bus.Op2} <= '0;
    else {bus.Muxrs1, bus.Op1, bus.ALU, bus.WriteEnable, bus.MemWrite, bus.Op2} <= nxt;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and random decode checks against a table-driven reference model.
module tb_control_unit;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  control_unit_if bus ();
  control_unit dut (.clock(clock), .resetn(resetn), .bus(bus));
  always #5 clock = ~clock;

  function automatic logic [9:0] outv();
    return {bus.Muxrs1, bus.Op1, bus.ALU, bus.WriteEnable, bus.MemWrite, bus.Op2};
  endfunction

  // Expected vector {Muxrs1, Op1, ALU, WE, MW, Op2} from the decode table.
  function automatic logic [9:0] model(input logic [6:0] op, input logic [2:0] f3);
    logic [1:0] alu;
    bit ok;
    ok = 1;
    case (f3)
      3'b000: alu = 2'd0;
      3'b101: alu = 2'd1;
      3'b110: alu = 2'd2;
      3'b111: alu = 2'd3;
      default: begin alu = 2'd0; ok = 0; end
    endcase
    case (op)
      7'b0110011: return ok ? {1'b0, 2'd0, alu, 1'b1, 1'b0, 3'd0} : 10'd0;
      7'b0010011: return ok ? {1'b0, 2'd0, alu, 1'b1, 1'b0, (f3 == 3'b101) ? 3'd4 : 3'd1} : 10'd0;
      7'b0110111: return {1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 3'd3};
      7'b0000011: return (f3 == 3'b010) ? {1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 3'd1} : 10'd0;
      7'b0100011: return (f3 == 3'b010) ? {1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 3'd2} : 10'd0;
      default: return 10'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3);
    bus.Opcode = op;
    bus.Funct3 = f3;
    @(posedge clock);
    #1;
    check(tag, outv(), model(op, f3));
  endtask

  logic [6:0] ops [6] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011, 7'b0100011, 7'b1111111};

  initial begin
    bus.Opcode = 7'b0110011;
    bus.Funct3 = 3'b000;
    #1 resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1 check("reset_hold", outv(), 10'd0);
    end
    #2 resetn = 1'b1;
    @(posedge clock);
    #1 check("reset_release", outv(), {1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 3'd0});
    step("r_add", 7'b0110011, 3'b000);
    step("r_srl", 7'b0110011, 3'b101);
    step("r_or", 7'b0110011, 3'b110);
    step("r_and", 7'b0110011, 3'b111);
    step("r_f3_001", 7'b0110011, 3'b001);
    check("r_f3_001_zero", outv(), 10'd0);
    step("lui", 7'b0110111, 3'b010);
    check("lui_muxrs1", {9'd0, bus.Muxrs1}, 10'd1);
    step("sw", 7'b0100011, 3'b010);
    step("lw", 7'b0000011, 3'b010);
    step("i_add", 7'b0010011, 3'b000);
    step("i_srl", 7'b0010011, 3'b101);
    step("i_or", 7'b0010011, 3'b110);
    step("i_and", 7'b0010011, 3'b111);
    step("illegal_op", 7'b1111111, 3'b000);
    step("lw_f3_000", 7'b0000011, 3'b000);
    step("sw_f3_001", 7'b0100011, 3'b001);
    check("sw_f3_001_mw", {9'd0, bus.MemWrite}, 10'd0);
    step("r_add2", 7'b0110011, 3'b000);
    bus.Opcode = 7'b0100011;
    bus.Funct3 = 3'b010;
    #2 check("between_edges", outv(), model(7'b0110011, 3'b000));
    @(posedge clock);
    #1 check("sw_edge", outv(), model(7'b0100011, 3'b010));
    #2 resetn = 1'b0;
    #1 check("async_reset_mw", {9'd0, bus.MemWrite}, 10'd0);
    check("async_reset_all", outv(), 10'd0);
    @(posedge clock);
    #1 check("reset_low_edge", outv(), 10'd0);
    #2 resetn = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
      step("random", op, 3'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Registered main decoder for the single-cycle-style RV32I datapath subset.
- Decodes the 7-bit Opcode and 3-bit Funct3 of the current instruction into datapath control: rs1 source, write-back source, ALU operation, operand-B select, register-file write enable and data-memory write enable.
- Sits between the instruction fetch/register stage and the datapath muxes, register file, ALU and data memory.

Parameters:
- none

Ports:
- clock  input  1  system clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- Opcode  input  7  instruction bits [6:0]
- Funct3  input  3  instruction bits [14:12]
- Muxrs1  output  1  rs1 address select: 0 = instruction rs1 field, 1 = forced x0
- Op1  output  2  write-back source: 00 ALU result, 01 data-memory read data, 10/11 reserved (never driven)
- ALU  output  2  ALU op: 00 ADD, 01 SRL, 10 OR, 11 AND
- WriteEnable  output  1  register-file write enable
- MemWrite  output  1  data-memory write enable
- Op2  output  3  ALU operand-B select: 000 rs2, 001 I-imm, 010 S-imm, 011 U-imm, 100 shamt (imm[4:0] zero-extended), 101-111 reserved

Behaviour:
- Reset: resetn low asynchronously forces all outputs to 0 (Muxrs1=0, Op1=00, ALU=00, WriteEnable=0, MemWrite=0, Op2=000). Outputs hold 0 while resetn is low; decoding resumes on the first rising clock edge after release.
- Latency: combinational decode of Opcode/Funct3, registered on the rising edge of clock. Outputs reflect inputs sampled at the previous edge (1-cycle latency). No handshake.
- Decode table (Muxrs1, Op1, ALU, WriteEnable, MemWrite, Op2):
  - R-type 0110011: 0, 00, ALU from Funct3, 1, 0, 000.
  - I-ALU 0010011: 0, 00, ALU from Funct3, 1, 0. Op2 = 100 when Funct3=101, else 001.
  - LUI 0110111: 1, 00, 00, 1, 0, 011. Funct3 is ignored. Result is x0 + U-imm.
  - LOAD 0000011 with Funct3=010 (LW): 0, 01, 00, 1, 0, 001.
  - STORE 0100011 with Funct3=010 (SW): 0, 00, 00, 0, 1, 010.
- Funct3-to-ALU mapping for R-type and I-ALU: 000 -> 00 ADD, 101 -> 01 SRL, 110 -> 10 OR, 111 -> 11 AND.
- There is no Funct7 input:
  - SUB decodes as ADD.
  - SRA/SRAI decode as SRL/SRLI.
- Illegal or unsupported cases register all-zero outputs (no register write, no memory write):
  - any other opcode;
  - R-type or I-ALU with Funct3 in {001, 010, 011, 100};
  - LOAD or STORE with Funct3 other than 010.
- The all-zero safe vector is identical to the reset vector.
- X/unknown inputs need not be handled. Reserved Op1/Op2 codes are never produced.
- Implementation structure:
  - A combinational next-value block with explicit default assignments, so no latches are inferred.
  - A single always block with async reset for the output registers.

Test Plan:
- Reset: hold resetn=0 with Opcode=0110011, Funct3=000 while toggling clock -> all outputs 0. Release resetn -> after the next rising edge, outputs are Muxrs1=0, Op1=00, ALU=00, WE=1, MW=0, Op2=000.
- R-type sweep: Opcode=0110011 with Funct3=000/101/110/111 -> ALU=00/01/10/11, Op2=000, WE=1, MW=0, each one edge after the change. Funct3=001 -> all zeros.
- U/S/L: LUI (0110111, Funct3=010) -> Muxrs1=1, Op2=011, WE=1. SW (0100011, Funct3=010) -> MW=1, WE=0, Op2=010. LW (0000011, Funct3=010) -> Op1=01, WE=1, Op2=001, ALU=00.
- I-ALU sweep: Opcode=0010011 with Funct3=000/101/110/111 -> ALU=00/01/10/11, Op2=001/100/001/001, WE=1, MW=0.
- Illegal: Opcode=1111111 -> all zeros. LW opcode with Funct3=000 -> all zeros. SW opcode with Funct3=001 -> MW=0.
- Latency/reset mid-operation:
  - Change inputs between edges -> outputs change only at the rising edge.
  - Assert resetn low mid-cycle while SW is decoded -> MemWrite drops to 0 immediately, without waiting for a clock edge.
